stb_event_rx: RTL and testbench

- Receive-side consumer for level-held strobes that arrive from a strobe CDC synchronizer in the local clock domain.
- Converts each low-to-high transition of the synchronized strobe into exactly one queued event.
- Presents pending events to downstream logic (frame-buffer pointer control) over a valid/ready handshake.
- Detects a strobe stuck high and flags pending-count overflow.

---
 rtl/stb_event_rx.sv | 126 ++++++++++++
 tb/tb_stb_event_rx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stb_event_rx.sv
// Turns rising edges of a synchronized strobe level into queued events drained over valid/ready.
// Also flags a strobe held high too long and edges lost to a saturated pending counter.
module stb_event_rx #(
  parameter int CNT_WIDTH    = 4,
  parameter int HIGH_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 stb_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic                 evt_pulse_o,
  output logic [CNT_WIDTH-1:0] pending_o,
  output logic                 ovf_o,
  output logic                 stuck_o,
  input  logic                 flag_clr_i
);

  localparam int HCNT_W = $clog2(HIGH_TIMEOUT + 1);

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_STUCK = 2'd3;

  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [HCNT_W-1:0]    HCNT_TO  = HCNT_W'(HIGH_TIMEOUT);
  localparam logic [HCNT_W-1:0]    HCNT_ONE = HCNT_W'(1);

  logic [1:0]           state_q, state_d;
  logic [HCNT_W-1:0]    hcnt_q, hcnt_d, hcnt_inc;
  logic [CNT_WIDTH-1:0] pending_q, pending_d;
  logic                 pulse_q, pulse_d;
  logic                 ovf_q, ovf_d;
  logic                 stuck_q, stuck_d;
  logic                 rise, accept, ovf_set, stuck_set;

  assign hcnt_inc = hcnt_q + HCNT_ONE;

  // ARM waits for a low level so a strobe already high after reset is never counted.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    rise      = 1'b0;
    stuck_set = 1'b0;
    case (state_q)
      ST_ARM: begin
        if (!stb_i) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (stb_i) begin
          state_d = ST_HIGH;
          hcnt_d  = HCNT_ONE;
          rise    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!stb_i) begin
          state_d = ST_LOW;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == HCNT_TO) begin
            state_d   = ST_STUCK;
            stuck_set = 1'b1;
          end
        end
      end
      ST_STUCK: begin
        if (!stb_i) begin
          state_d = ST_LOW;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_ARM;
        hcnt_d  = '0;
      end
    endcase
  end

  assign accept = evt_valid_o & evt_ready_i;

  // A simultaneous rise and accept cancel out; the counter saturates instead of wrapping.
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    case ({rise, accept})
      2'b10: begin
        if (pending_q == PEND_MAX) ovf_set = 1'b1;
        else pending_d = pending_q + 1'b1;
      end
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  assign pulse_d = rise;
  assign ovf_d   = ovf_set | (ovf_q & ~flag_clr_i);
  assign stuck_d = stuck_set | (stuck_q & ~flag_clr_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_ARM;
      hcnt_q    <= '0;
      pending_q <= '0;
      pulse_q   <= 1'b0;
      ovf_q     <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      ovf_q     <= ovf_d;
      stuck_q   <= stuck_d;
    end
  end

  assign evt_valid_o = (pending_q != '0);
  assign evt_pulse_o = pulse_q;
  assign pending_o   = pending_q;
  assign ovf_o       = ovf_q;
  assign stuck_o     = stuck_q;

endmodule

// File: tb/tb_stb_event_rx.sv
// Directed bench for stb_event_rx with CNT_WIDTH=3 (max 7 pending) and HIGH_TIMEOUT=8.
module tb_stb_event_rx;

  localparam int CW = 3;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          stb = 1'b0;
  logic          ready = 1'b0;
  logic          clr = 1'b0;
  logic          valid, pulse, ovf, stuck;
  logic [CW-1:0] pending;

  int checkCount = 0;
  int passCount  = 0;
  int pulseSeen  = 0;

  stb_event_rx #(.CNT_WIDTH(CW), .HIGH_TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rstN),
    .stb_i       (stb),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_pulse_o (pulse),
    .pending_o   (pending),
    .ovf_o       (ovf),
    .stuck_o     (stuck),
    .flag_clr_i  (clr)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle just past the edge that samples them.
  task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic c);
    rstN  = r;
    stb   = s;
    ready = rd;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic checkAll(input string tag, input int expPend, input logic expValid,
                          input logic expPulse, input logic expOvf, input logic expStuck);
    checkOutput({tag, ".pending"}, 32'(pending), 32'(expPend));
    checkOutput({tag, ".valid"},   32'(valid),   32'(expValid));
    checkOutput({tag, ".pulse"},   32'(pulse),   32'(expPulse));
    checkOutput({tag, ".ovf"},     32'(ovf),     32'(expOvf));
    checkOutput({tag, ".stuck"},   32'(stuck),   32'(expStuck));
  endtask

  // One isolated strobe pulse: one high cycle then one low cycle, ready held low.
  task automatic onePulse();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");

    // Reset with the strobe already high
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkAll("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Level high out of reset must not count
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("arm_high.pulse", 32'(pulse), 0);
    end
    checkOutput("arm_high.pending", 32'(pending), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("first_rise", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("first_hold1", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("first_hold2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("drain1", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three pulses queued, then drained one per cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("three.pulse", 32'(pulse), 1);
      checkOutput("three.pending", 32'(pending), 32'(i + 1));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("acc_2", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("acc_1", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("acc_0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("ready_empty", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Rise and accept on the same edge leave pending unchanged
    onePulse();
    onePulse();
    checkOutput("pre_both.pending", 32'(pending), 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkAll("rise_and_accept", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAll("after_both", 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Saturate at 7; the eighth edge is dropped and flagged
    for (int i = 0; i < 5; i++) onePulse();
    checkAll("full", 7, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("sat_rise", 7, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkAll("ovf_clr", 7, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkAll("ovf_set_wins", 7, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkAll("ovf_clr2", 7, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("drain7", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stuck detection: 20 high cycles give one event, stuck after the 8th
    pulseSeen = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if (pulse) pulseSeen++;
      if (i == 7) checkOutput("stuck_c7", 32'(stuck), 0);
      if (i == 8) checkOutput("stuck_c8", 32'(stuck), 1);
    end
    checkOutput("stuck.events", 32'(pulseSeen), 1);
    checkAll("stuck_end", 1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("after_stuck_rise", 2, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAll("stuck_sticky", 2, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkAll("stuck_clr", 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation with pending=5, stuck set and strobe high
    onePulse();
    onePulse();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst.pending", 32'(pending), 5);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst.stuck", 32'(stuck), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkAll("mid_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("post_rst_high.pulse", 32'(pulse), 0);
    end
    checkOutput("post_rst_high.pending", 32'(pending), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("post_rst_rise", 1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
